uart_tx_feeder: RTL and testbench

Byte buffer and launch controller placed directly upstream of the UART transmitter. Producers push bytes into a DEPTH-entry FIFO at any rate. The block pops bytes one at a time and hands each to the transmitter's `i_TX_DV`/`i_TX_Byte` inputs. It waits for the transmitter's `o_TX_Active`/`o_TX_Done` status before launching the next byte, so no byte is lost while the transmitter is busy or in cleanup.

---
 rtl/uart_tx_feeder.sv | 125 ++++++++++++
 tb/tb_uart_tx_feeder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch FSM that feeds a UART transmitter one byte at a time.
// Optional sticky o_Overflow port is enabled by defining UART_TX_FEEDER_OVF_EN.
module uart_tx_feeder #(
  parameter int DEPTH = 16
) (
  input  logic                     i_Clock,
  input  logic                     i_Rst_L,
  input  logic                     i_Wr_En,
  input  logic [7:0]               i_Wr_Byte,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Count,
  output logic                     o_TX_DV,
  output logic [7:0]               o_TX_Byte,
  input  logic                     i_TX_Active,
  input  logic                     i_TX_Done
`ifdef UART_TX_FEEDER_OVF_EN
  ,
  output logic                     o_Overflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q;
  state_e        state_q;
  logic          tx_dv_q;
  logic [7:0]    tx_byte_q;
  logic          wr_accept;
  logic          pop;

  // Acceptance looks only at the pre-edge full flag, so a write while full
  // is dropped even when a pop frees a slot on the same edge.
  always_comb begin
    wr_accept = i_Wr_En && !full_q;
    pop       = (state_q == S_IDLE) && !empty_q && !i_TX_Active && !i_TX_Done;
    wr_ptr_d  = wr_accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(wr_accept) - CW'(pop);
  end

  // NOTE: storage has no reset; clearing pointers and count already discards
  // every queued byte, and a reset-free array maps onto plain RAM.
  always_ff @(posedge i_Clock) begin
    if (wr_accept) mem_q[wr_ptr_q] <= i_Wr_Byte;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            tx_byte_q <= mem_q[rd_ptr_q];
            tx_dv_q   <= 1'b1;
            state_q   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (i_TX_Active) begin
            tx_dv_q <= 1'b0;
            state_q <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (i_TX_Done) state_q <= S_IDLE;
        end
        default: begin
          tx_dv_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FEEDER_OVF_EN
  logic overflow_q;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L)                overflow_q <= 1'b0;
    else if (i_Wr_En && full_q)  overflow_q <= 1'b1;
  end

  assign o_Overflow = overflow_q;
`endif

  assign o_Full    = full_q;
  assign o_Empty   = empty_q;
  assign o_Count   = count_q;
  assign o_TX_DV   = tx_dv_q;
  assign o_TX_Byte = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder; the transmitter handshake
// (Active/Done) is driven by hand, step by step.
module tb_uart_tx_feeder;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_byte;
  logic       full, empty;
  logic [4:0] count;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active, tx_done;
`ifdef UART_TX_FEEDER_OVF_EN
  logic       overflow;
`endif

  int checks   = 0;
  int failures = 0;

  uart_tx_feeder #(.DEPTH(16)) dut (
    .i_Clock     (clk),
    .i_Rst_L     (rst_n),
    .i_Wr_En     (wr_en),
    .i_Wr_Byte   (wr_byte),
    .o_Full      (full),
    .o_Empty     (empty),
    .o_Count     (count),
    .o_TX_DV     (tx_dv),
    .o_TX_Byte   (tx_byte),
    .i_TX_Active (tx_active),
    .i_TX_Done   (tx_done)
`ifdef UART_TX_FEEDER_OVF_EN
    ,
    .o_Overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_byte = b;
    tick();
    wr_en   = 1'b0;
  endtask

  // One full handshake for a byte already queued with the FSM in IDLE.
  task automatic serve(input logic [7:0] exp_byte);
    tx_active = 1'b0;
    tx_done   = 1'b0;
    tick();
    check("serve_dv", 16'(tx_dv), 16'h1);
    check("serve_byte", 16'(tx_byte), 16'(exp_byte));
    tx_active = 1'b1;
    tick();
    check("serve_dv_fall", 16'(tx_dv), 16'h0);
    tx_active = 1'b0;
    tx_done   = 1'b1;
    tick();
    tx_done   = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b1;
    wr_en     = 1'b0;
    wr_byte   = 8'h00;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    #1 rst_n  = 1'b0;
    #1;
    check("rst_count", 16'(count), 16'h0);
    check("rst_empty", 16'(empty), 16'h1);
    check("rst_full", 16'(full), 16'h0);
    check("rst_dv", 16'(tx_dv), 16'h0);
    check("rst_byte", 16'(tx_byte), 16'h00);
`ifdef UART_TX_FEEDER_OVF_EN
    check("rst_ovf", 16'(overflow), 16'h0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single byte on the idle path
    push(8'hA5);
    check("w_count", 16'(count), 16'h1);
    check("w_empty", 16'(empty), 16'h0);
    check("w_dv_early", 16'(tx_dv), 16'h0);
    tick();
    check("launch_dv", 16'(tx_dv), 16'h1);
    check("launch_byte", 16'(tx_byte), 16'hA5);
    check("launch_count", 16'(count), 16'h0);
    check("launch_empty", 16'(empty), 16'h1);
    tick();
    check("launch_hold", 16'(tx_dv), 16'h1);
    tx_active = 1'b1;
    tick();
    check("dv_fall", 16'(tx_dv), 16'h0);
    check("byte_hold", 16'(tx_byte), 16'hA5);
    tx_active = 1'b0;
    tx_done   = 1'b1;
    tick();
    push(8'h5A);
    check("gate_count", 16'(count), 16'h1);
    tick();
    check("gate_done_dv", 16'(tx_dv), 16'h0);
    check("gate_done_cnt", 16'(count), 16'h1);
    tx_done = 1'b0;
    tick();
    check("gate_rel_dv", 16'(tx_dv), 16'h1);
    check("gate_rel_byte", 16'(tx_byte), 16'h5A);
    check("gate_rel_cnt", 16'(count), 16'h0);
    tx_active = 1'b1;
    tick();
    tx_active = 1'b0;
    tx_done   = 1'b1;
    tick();
    tx_done = 1'b0;

    // Burst of three, served in order
    tx_active = 1'b1;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    check("burst_count", 16'(count), 16'h3);
    serve(8'h01);
    serve(8'h02);
    serve(8'h03);
    check("burst_empty", 16'(empty), 16'h1);

    // Fill to DEPTH with the transmitter busy, then one dropped write
    tx_active = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    check("fill_full", 16'(full), 16'h1);
    check("fill_count", 16'(count), 16'h10);
    push(8'hEE);
    check("drop_count", 16'(count), 16'h10);
    check("drop_full", 16'(full), 16'h1);
`ifdef UART_TX_FEEDER_OVF_EN
    check("drop_ovf", 16'(overflow), 16'h1);
`endif

    // Full plus simultaneous pop: the write is still dropped
    tx_active = 1'b0;
    push(8'hFF);
    check("fp_count", 16'(count), 16'hF);
    check("fp_full", 16'(full), 16'h0);
    check("fp_dv", 16'(tx_dv), 16'h1);
    check("fp_byte", 16'(tx_byte), 16'h10);
    tx_active = 1'b1;
    tick();
    tx_active = 1'b0;
    tx_done   = 1'b1;
    tick();
    tx_done = 1'b0;
    for (int i = 1; i < 16; i++) serve(8'(8'h10 + i));
    check("fp_drain_empty", 16'(empty), 16'h1);
    check("fp_drain_count", 16'(count), 16'h0);

    // Pointer wrap: 40 bytes in chunks of ten
    for (int c = 0; c < 4; c++) begin
      tx_active = 1'b1;
      for (int i = 0; i < 10; i++) push(8'(c * 10 + i));
      check("wrap_count", 16'(count), 16'hA);
      for (int i = 0; i < 10; i++) serve(8'(c * 10 + i));
    end
    check("wrap_empty", 16'(empty), 16'h1);
`ifdef UART_TX_FEEDER_OVF_EN
    check("wrap_ovf_sticky", 16'(overflow), 16'h1);
`endif

    // Reset in the middle of a launch with five bytes still queued
    tx_active = 1'b1;
    for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
    tx_active = 1'b0;
    tick();
    check("mid_dv", 16'(tx_dv), 16'h1);
    check("mid_count", 16'(count), 16'h5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_dv", 16'(tx_dv), 16'h0);
    check("mid_rst_count", 16'(count), 16'h0);
    check("mid_rst_empty", 16'(empty), 16'h1);
    check("mid_rst_byte", 16'(tx_byte), 16'h00);
`ifdef UART_TX_FEEDER_OVF_EN
    check("mid_rst_ovf", 16'(overflow), 16'h0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("post_rst_dv", 16'(tx_dv), 16'h0);
    check("post_rst_count", 16'(count), 16'h0);
    check("post_rst_empty", 16'(empty), 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
